// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv
//  Purpose  : Multi-cycle execute unit. Single-cycle RV32I integer operations
//             plus an iterative RV32M multiply (radix-2 shift-add) and
//             divide (restoring) datapath, behind a valid/ready handshake.
//             Result and zero flag are registered and held until consumed.
//  Ports    : clk, resetn (sync, active-low)
//             in_valid / in_ready    - request handshake (ready == IDLE)
//             mext, alu_op, sign_op  - operation select
//             srcA, srcB             - operands
//             out_valid / out_ready  - result handshake (valid == DONE)
//             result, zero           - registered outputs
//  Config   : ALU_MULDIV_EN - when defined, builds the MUL/DIV datapath.
//             When undefined, every mext=1 request completes in one cycle
//             with result=0.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mext,
    input  logic [2:0]       alu_op,
    input  logic             sign_op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DONE = 2'd3;
`ifdef ALU_MULDIV_EN
    localparam logic [1:0]     c_MUL      = 2'd1;
    localparam logic [1:0]     c_DIV      = 2'd2;
    localparam logic [SHW-1:0] c_CNT_LOAD = SHW'(WIDTH - 1);
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             w_accept;
    logic             w_long;       // accepted op needs the iterative datapath
    logic [WIDTH-1:0] w_quick;      // result of a single-cycle op
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sra;
    logic [SHW-1:0]   w_shamt;

    assign w_accept  = in_valid && (r_state == c_IDLE);
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign zero      = r_zero;

    // ------------------------------------------------------------------
    // Base integer operations
    // ------------------------------------------------------------------
    assign w_shamt = srcB[SHW-1:0];
    // Kept separate so the arithmetic shift is evaluated in a signed context.
    assign w_sra   = $unsigned($signed(srcA) >>> w_shamt);

    always_comb begin
        w_base = '0;
        case (alu_op)
            3'b000: w_base = sign_op ? (srcA + srcB) : (srcA - srcB);
            3'b001: w_base = srcA << w_shamt;
            3'b010: w_base = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            3'b011: w_base = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            3'b100: w_base = srcA ^ srcB;
            3'b101: w_base = sign_op ? w_sra : (srcA >> w_shamt);
            3'b110: w_base = srcA | srcB;
            3'b111: w_base = srcA & srcB;
            default: w_base = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // ------------------------------------------------------------------
    // M-extension: operand signs, magnitudes and divide special cases
    // ------------------------------------------------------------------
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_div_special;
    logic [WIDTH-1:0] w_special_res;

    always_comb begin
        if (alu_op[2]) begin
            // DIV/REM signed, DIVU/REMU unsigned
            w_a_signed = !alu_op[0];
            w_b_signed = !alu_op[0];
        end else begin
            // MULH: both signed; MULHSU: A only; MUL/MULHU: unsigned
            w_a_signed = alu_op[1] ^ alu_op[0];
            w_b_signed = (alu_op[1:0] == 2'b01);
        end
    end

    assign w_a_neg = w_a_signed & srcA[WIDTH-1];
    assign w_b_neg = w_b_signed & srcB[WIDTH-1];
    assign w_a_mag = w_a_neg ? -srcA : srcA;
    assign w_b_mag = w_b_neg ? -srcB : srcB;

    assign w_div_zero    = (srcB == '0);
    assign w_div_ovf     = !alu_op[0] && (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (&srcB);
    assign w_div_special = alu_op[2] && (w_div_zero || w_div_ovf);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = alu_op[1] ? srcA : '1;
        end else begin
            w_special_res = alu_op[1] ? '0 : srcA;
        end
    end

    assign w_long = mext && !w_div_special;

    always_comb begin
        w_quick = w_base;
        if (mext) begin
            w_quick = w_special_res;
        end
    end

    // ------------------------------------------------------------------
    // Iterative datapath. r_acc holds {product high, multiplier} while
    // multiplying and {partial remainder, dividend/quotient} while dividing.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;     // |A| for multiply, |B| for divide
    logic [1:0]         r_op;
    logic               r_neg_q;    // negate product / quotient
    logic               r_neg_r;    // negate remainder
    logic [SHW-1:0]     r_cnt;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg_q ? -w_mul_next : w_mul_next;
    assign w_mul_res  = (r_op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_div_res;
    logic [WIDTH-1:0]   w_fin_res;

    // Shifted partial remainder is below 2*divisor, so the difference fits
    // in WIDTH bits whenever the subtraction succeeds.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                  : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    assign w_quot      = w_div_next[WIDTH-1:0];
    assign w_rem       = w_div_next[2*WIDTH-1:WIDTH];
    assign w_div_res   = r_op[1] ? (r_neg_r ? -w_rem : w_rem)
                                 : (r_neg_q ? -w_quot : w_quot);
    assign w_fin_res   = (r_state == c_MUL) ? w_mul_res : w_div_res;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_accept && w_long) begin
            r_cnt   <= c_CNT_LOAD;
            r_op    <= alu_op[1:0];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (alu_op[2]) begin
                r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                r_opnd <= w_b_mag;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                r_opnd <= w_a_mag;
            end
        end else if (r_state == c_MUL) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == c_DIV) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    assign w_long = 1'b0;

    always_comb begin
        w_quick = w_base;
        if (mext) begin
            w_quick = '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
`ifdef ALU_MULDIV_EN
                    if (w_long) begin
                        w_state_next = alu_op[2] ? c_DIV : c_MUL;
                    end else begin
                        w_state_next = c_DONE;
                    end
`else
                    w_state_next = c_DONE;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            c_MUL, c_DIV: begin
                if (r_cnt == '0) begin
                    w_state_next = c_DONE;
                end
            end
`endif
            c_DONE: begin
                if (out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register: written on single-cycle accept or on the final
    // iteration (with sign correction folded in), otherwise held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_accept && !w_long) begin
            r_result <= w_quick;
            r_zero   <= (w_quick == '0);
        end
`ifdef ALU_MULDIV_EN
        else if (((r_state == c_MUL) || (r_state == c_DIV)) && (r_cnt == '0)) begin
            r_result <= w_fin_res;
            r_zero   <= (w_fin_res == '0);
        end
`endif
    end

endmodule
`default_nettype wire
